// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, diff = a - b - bin, LSB first
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid, in_ready  operand handshake (a, b, bin sampled in IDLE only)
//   a, b, bin           minuend, subtrahend, borrow in
//   out_valid, out_ready result handshake (diff, bout held until taken)
//   diff, bout          difference modulo 2^WIDTH and final borrow
//   busy                operation in progress or result pending
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_nxt;
  logic             last_bit;

  assign a_i      = a_sh[0];
  assign b_i      = b_sh[0];
  assign d_i      = a_i ^ b_i ^ br;
  assign br_nxt   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // in_ready is a pure state decode, masked while reset is held
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          // entering at the MSB means bit 0 reaches diff[0] after WIDTH shifts
          diff <= {d_i, diff[WIDTH-1:1]};
          if (last_bit) bout <= br_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
